// File: rtl/framebuffer_arbiter_pkg.sv
// rtl/framebuffer_arbiter_pkg.sv - shared frame geometry, widths and arbiter state encoding
package framebuffer_arbiter_pkg;

    localparam int FB_MAX_PIXELS = 307200;  // 640x480
    localparam int FB_ADDR_W     = 20;
    localparam int FB_DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } fb_state_e;

endpackage

// File: rtl/framebuffer_arbiter_starve.sv
// rtl/framebuffer_arbiter_starve.sv - write starvation counter, flags when the write must be forced
module fb_starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count;

    // clr wins over inc; hold at the limit so the count can never wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LAST);

endmodule

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - single-port framebuffer arbiter, VGA reads over Sobel writes with starvation forcing
module framebuffer_arbiter #(
    parameter int MAX_PIXELS = framebuffer_arbiter_pkg::FB_MAX_PIXELS,
    parameter int ADDR_W     = framebuffer_arbiter_pkg::FB_ADDR_W,
    parameter int DATA_W     = framebuffer_arbiter_pkg::FB_DATA_W,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err,
    output logic              rd_late
);

    import framebuffer_arbiter_pkg::*;

    // one extra bit so the limit itself is representable and the compare is unsigned, untruncated
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MAX_PIXELS);

    fb_state_e state, next_state;
    logic      started;
    logic      hit, force_wr, cnt_inc, cnt_clr;
    logic      rd_in_range, wr_in_range;
    logic      rd_oor;

    logic              nxt_rd_gnt, nxt_wr_gnt, nxt_we, nxt_err, nxt_late;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;

    assign rd_in_range = ({1'b0, rd_addr} < LIMIT);
    assign wr_in_range = ({1'b0, wr_addr} < LIMIT);

    // started holds arbitration off for the first edge after reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            started <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
        end
    end

    assign force_wr = started && hit && wr_req && (state != ST_WR);

    // a requester just granted sits out one cycle; a held read still blocks the write unless forced
    always_comb begin
        next_state = ST_IDLE;
        if (!started) begin
            next_state = ST_IDLE;
        end else if (rd_req && !force_wr) begin
            next_state = (state == ST_RD) ? ST_IDLE : ST_RD;
        end else if (wr_req && state != ST_WR) begin
            next_state = ST_WR;
        end
    end

    always_comb begin
        nxt_rd_gnt = (next_state == ST_RD);
        nxt_wr_gnt = (next_state == ST_WR);
        nxt_addr   = '0;
        nxt_wdata  = '0;
        nxt_we     = 1'b0;
        nxt_err    = 1'b0;
        nxt_late   = force_wr && rd_req;
        if (next_state == ST_RD) begin
            nxt_addr = rd_addr;
            nxt_err  = !rd_in_range;
        end else if (next_state == ST_WR) begin
            nxt_addr  = wr_addr;
            nxt_wdata = wr_data;
            nxt_we    = wr_in_range;
            nxt_err   = !wr_in_range;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_gnt    <= 1'b0;
            wr_gnt    <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
            rd_late   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_oor    <= 1'b0;
        end else begin
            rd_gnt    <= nxt_rd_gnt;
            wr_gnt    <= nxt_wr_gnt;
            mem_addr  <= nxt_addr;
            mem_we    <= nxt_we;
            mem_wdata <= nxt_wdata;
            addr_err  <= nxt_err;
            rd_late   <= nxt_late;
            rd_valid  <= rd_gnt;
            rd_oor    <= rd_gnt && addr_err;
        end
    end

    // RAM data lands one cycle after the read grant; out-of-range reads return zero
    assign rd_data = (rd_valid && !rd_oor) ? mem_rdata : '0;

    // the grant cycle itself also clears, since the requester is still holding wr_req then
    assign cnt_inc = wr_req && (next_state != ST_WR);
    assign cnt_clr = !wr_req || (next_state == ST_WR) || (state == ST_WR);

    fb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .hit   (hit)
    );

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - randomized bench for framebuffer_arbiter against a behavioural model
module tb_framebuffer_arbiter;

    localparam int MAXP  = 307200;
    localparam int AW    = 20;
    localparam int DW    = 8;
    localparam int MAXW  = 8;
    localparam int CYCLES = 4000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          addr_err;
    logic          rd_late;

    framebuffer_arbiter #(
        .MAX_PIXELS (MAXP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err),
        .rd_late   (rd_late)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // single-port RAM, read-first, one-cycle read latency; unwritten locations read as zero
    logic [DW-1:0] ram [int];
    always @(posedge clock) begin
        int a;
        a = int'(mem_addr);
        mem_rdata <= ram.exists(a) ? ram[a] : '0;
        if (mem_we) ram[a] = mem_wdata;
    end

    // reference model: who gets the port this cycle, decided from the protocol rules
    // m_last: 0 none, 1 read, 2 write granted in the previous cycle
    logic [DW-1:0] shadow [int];
    int  m_last, m_wait, choice;
    bit  m_started, forced, inr;
    int  a_sel;
    logic [DW-1:0] m_pend;
    bit  exp_rd_gnt, exp_wr_gnt, exp_we, exp_err, exp_late, exp_valid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_started = 0; m_last = 0; m_wait = 0; m_pend = '0;
            exp_rd_gnt = 0; exp_wr_gnt = 0; exp_we = 0; exp_err = 0;
            exp_late = 0; exp_valid = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        end else begin
            exp_valid = (m_last == 1);
            exp_rdata = m_pend;
            forced = m_started && wr_req && (m_last != 2) && (m_wait == MAXW - 1);
            choice = 0;
            if (m_started) begin
                if (rd_req && !forced)          choice = (m_last == 1) ? 0 : 1;
                else if (wr_req && m_last != 2) choice = 2;
            end
            exp_late = forced && rd_req;
            if (choice == 2 || !wr_req || m_last == 2) m_wait = 0;
            else if (m_wait < MAXW - 1)                m_wait = m_wait + 1;
            exp_rd_gnt = (choice == 1);
            exp_wr_gnt = (choice == 2);
            exp_addr   = (choice == 1) ? rd_addr : wr_addr;
            exp_wdata  = wr_data;
            a_sel      = int'(exp_addr);
            inr        = (a_sel < MAXP);
            exp_err    = (choice != 0) && !inr;
            exp_we     = (choice == 2) && inr;
            if (choice == 1) m_pend = inr ? (shadow.exists(a_sel) ? shadow[a_sel] : '0) : '0;
            if (exp_we) shadow[a_sel] = wr_data;
            m_last    = choice;
            m_started = 1;
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return AW'($urandom_range(0, 15));
        else if (r == 7) return AW'(MAXP - 1);
        else if (r == 8) return AW'(MAXP);
        else             return {AW{1'b1}};
    endfunction

    int rd_pct, wr_pct, rst_hold;

    initial begin
        rst_hold = 0;
        // reset state, with a read already waiting at release
        repeat (3) begin
            @(negedge clock);
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_rd_data", rd_data, 0);
        end
        rd_req  = 1'b1;
        rd_addr = AW'(5);
        reset   = 1'b0;
        @(negedge clock);
        chk("first_edge_no_grant", rd_gnt, 0);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            if (cyc > 0) @(negedge clock);
            rd_pct = (cyc < CYCLES / 2) ? 90 : 25;
            wr_pct = (cyc < CYCLES / 2) ? 30 : 75;

            chk("rd_gnt", rd_gnt, exp_rd_gnt);
            chk("wr_gnt", wr_gnt, exp_wr_gnt);
            chk("mem_we", mem_we, exp_we);
            chk("addr_err", addr_err, exp_err);
            chk("rd_late", rd_late, exp_late);
            chk("rd_valid", rd_valid, exp_valid);
            if (reset) begin
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_rd_data", rd_data, 0);
            end else begin
                if (exp_rd_gnt || exp_wr_gnt) chk("mem_addr", mem_addr, exp_addr);
                if (exp_wr_gnt)               chk("mem_wdata", mem_wdata, exp_wdata);
                if (exp_valid)                chk("rd_data", rd_data, exp_rdata);
            end

            // reset sequencing: occasionally hit it right in a read grant cycle
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b0;
            end else if ((rd_gnt && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0) begin
                reset    = 1'b1;
                rst_hold = 2;
            end

            // requesters hold until granted, sometimes re-request immediately
            if (rd_req && rd_gnt && !reset) begin
                rd_req = ($urandom_range(0, 1) == 1);
                if (rd_req) rd_addr = pick_addr();
            end else if (!rd_req && $urandom_range(0, 99) < rd_pct) begin
                rd_req  = 1'b1;
                rd_addr = pick_addr();
            end
            if (wr_req && wr_gnt && !reset) begin
                wr_req = ($urandom_range(0, 1) == 1);
                if (wr_req) begin
                    wr_addr = pick_addr();
                    wr_data = DW'($urandom);
                end
            end else if (!wr_req && $urandom_range(0, 99) < wr_pct) begin
                wr_req  = 1'b1;
                wr_addr = pick_addr();
                wr_data = DW'($urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
